imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_word_assembler.sv | 43 ++++
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and widths for the instruction-memory loader
package imem_loader_pkg;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        BYTE,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - packs big-endian bytes into 32-bit instruction words
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_clear       restart at byte 0 (new load armed)
//   i_shift       a stream byte is accepted this cycle
//   i_byte        the accepted byte
//   o_word_full   this accepted byte is the 4th of the word
//   o_word        assembled word (complete the cycle after o_word_full)
import imem_loader_pkg::*;

module imem_word_assembler (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic [7:0]        i_byte,
    output logic              o_word_full,
    output logic [WORD_W-1:0] o_word
);

    logic [1:0]        r_idx;
    logic [WORD_W-1:0] r_word;

    // Flagged combinationally so the FSM can move to WRITE on the same edge
    // that captures the last byte.
    assign o_word_full = i_shift && (r_idx == 2'd3);
    assign o_word      = r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= 2'd0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx  <= 2'd0;
            r_word <= '0;
        end else if (i_shift) begin
            r_word <= {r_word[WORD_W-9:0], i_byte};
            r_idx  <= r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory and holds the CPU
//
// Optional feature macro: CHECKSUM_EN (trailing XOR checksum byte, CHK state).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           pulse arming a new load (ignored while a load is in progress)
//   in_valid/in_data/in_ready   byte stream handshake
//   imem_we/imem_addr/imem_wdata  one-cycle word write into instruction memory
//   cpu_hold        datapath stall, low only after a successful load
//   done, err       level status of the last load
import imem_loader_pkg::*;

module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned MAX_WORDS = 1 << (ADDR_W - 2);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
`ifdef CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_fire;
    logic              w_arm;
    logic              w_word_full;
    logic [WORD_W-1:0] w_word;
    logic [LEN_W-1:0]  w_len;

    // r_in_ready is high exactly in LEN_HI, LEN_LO, BYTE and CHK.
    assign w_fire = in_valid && r_in_ready;
    assign w_arm  = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign w_len  = {r_len[LEN_W-1:8], in_data};

    imem_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_arm),
        .i_shift     (w_fire && (r_state == BYTE)),
        .i_byte      (in_data),
        .o_word_full (w_word_full),
        .o_word      (w_word)
    );

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign err        = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_len      <= '0;
            r_count    <= '0;
`ifdef CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (w_arm) begin
                        r_state    <= LEN_HI;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
`ifdef CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                LEN_HI: begin
                    if (w_fire) begin
                        r_len[LEN_W-1:8] <= in_data;
                        r_state          <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_fire) begin
                        r_len   <= w_len;
                        r_count <= '0;
                        if (w_len == '0) begin
                            r_state    <= DONE;
                            r_in_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else if (32'(w_len) > MAX_WORDS) begin
                            r_state    <= ERR;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_state <= BYTE;
                        end
                    end
                end
                BYTE: begin
                    if (w_fire) begin
`ifdef CHECKSUM_EN
                        r_csum <= r_csum ^ in_data;
`endif
                        if (w_word_full) begin
                            r_state    <= WRITE;
                            r_in_ready <= 1'b0;
                            r_we       <= 1'b1;
                            // Wraps modulo 2^ADDR_W by truncation.
                            r_addr     <= ADDR_W'(BASE_ADDR + (32'(r_count) << 2));
                        end
                    end
                end
                WRITE: begin
                    r_count <= r_count + 16'd1;
                    if (r_count + 16'd1 == r_len) begin
`ifdef CHECKSUM_EN
                        r_state    <= CHK;
                        r_in_ready <= 1'b1;
`else
                        r_state    <= DONE;
                        r_cpu_hold <= 1'b0;
                        r_done     <= 1'b1;
`endif
                    end else begin
                        r_state    <= BYTE;
                        r_in_ready <= 1'b1;
                    end
                end
`ifdef CHECKSUM_EN
                CHK: begin
                    if (w_fire) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_csum) begin
                            r_state    <= DONE;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule
